// File: rtl/accum_pkg.sv
// Shared types and width helpers for the dual-lane frame accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Sum width must hold n*(2^w-1); w+clog2(n) always does.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lane_accum.sv
// One lane: mask mux, frame accumulator and masked-beat counter.
module lane_accum
    import accum_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int AW = acc_width(W, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic [W-1:0]            din,
    input  logic                    ct,
    output logic [AW-1:0]           sum,
    output logic [cnt_width(N)-1:0] mcnt
);

    localparam int MW = cnt_width(N);

    logic [W-1:0]  masked;
    logic [AW-1:0] acc_reg;
    logic [MW-1:0] mcnt_reg;

    // Pure data mux so the flag never steers control.
    assign masked = ct ? '0 : din;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= '0;
            mcnt_reg <= '0;
        end else if (load) begin
            acc_reg  <= AW'(masked);
            mcnt_reg <= MW'(ct);
        end else if (en) begin
            acc_reg  <= acc_reg + AW'(masked);
            mcnt_reg <= mcnt_reg + MW'(ct);
        end
    end

    assign sum  = acc_reg;
    assign mcnt = mcnt_reg;

endmodule

// File: rtl/dual_lane_accum.sv
// Accumulates N two-lane beats per frame and presents both sums under valid/ready.
module dual_lane_accum
    import accum_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int AW = acc_width(W, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in1,
    input  logic [W-1:0]            in2,
    input  logic                    ct1,
    input  logic                    ct2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           sum1,
    output logic [AW-1:0]           sum2,
    output logic [cnt_width(N)-1:0] mcnt1,
    output logic [cnt_width(N)-1:0] mcnt2
);

    localparam int MW = cnt_width(N);

    state_t        state_reg;
    logic [MW-1:0] cnt_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;

    logic accept;
    logic load;
    logic en;

    assign accept = in_valid && in_ready_reg;
    assign load   = accept && (state_reg == IDLE);
    assign en     = accept && (state_reg == ACC);

    // Handshake outputs are registered alongside the state, so neither
    // in_valid nor out_ready has a combinational path to them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg <= MW'(1);
                        if (N == 1) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + MW'(1);
                        if (cnt_reg == MW'(N - 1)) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= '0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cnt_reg       <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;

    logic [W-1:0]  lane_din  [2];
    logic          lane_ct   [2];
    logic [AW-1:0] lane_sum  [2];
    logic [MW-1:0] lane_mcnt [2];

    assign lane_din[0] = in1;
    assign lane_din[1] = in2;
    assign lane_ct[0]  = ct1;
    assign lane_ct[1]  = ct2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            lane_accum #(
                .W  (W),
                .N  (N),
                .AW (AW)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .load (load),
                .en   (en),
                .din  (lane_din[gi]),
                .ct   (lane_ct[gi]),
                .sum  (lane_sum[gi]),
                .mcnt (lane_mcnt[gi])
            );
        end
    endgenerate

    assign sum1  = lane_sum[0];
    assign sum2  = lane_sum[1];
    assign mcnt1 = lane_mcnt[0];
    assign mcnt2 = lane_mcnt[1];

endmodule

// File: tb/tb_dual_lane_accum.sv
// Self-checking bench: frame vector table plus a result scoreboard.
module tb_dual_lane_accum;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          ct1;
    logic          ct2;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] sum1;
    logic [AW-1:0] sum2;
    logic [MW-1:0] mcnt1;
    logic [MW-1:0] mcnt2;

    dual_lane_accum #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .ct1       (ct1),
        .ct2       (ct2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum1      (sum1),
        .sum2      (sum2),
        .mcnt1     (mcnt1),
        .mcnt2     (mcnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0][7:0] in1;
        logic [3:0][7:0] in2;
        logic [3:0]      ct1;
        logic [3:0]      ct2;
        int              gap_after;
        logic [AW-1:0]   s1;
        logic [AW-1:0]   s2;
        logic [MW-1:0]   m1;
        logic [MW-1:0]   m2;
    } vec_t;

    typedef struct {
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [MW-1:0] m1;
        logic [MW-1:0] m2;
        int            rise;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result monitor: pops the scoreboard on every output handshake.
    int   rise_cyc = -1;
    logic prev_ov  = 1'b0;
    logic took     = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   r;
        if (rst) begin
            prev_ov = 1'b0;
            took    = 1'b0;
        end else begin
            if (took) begin
                chk("ov_one_cycle", out_valid, 0);
                chk("idle_after_take", in_ready, 1);
            end
            r = (out_valid && !prev_ov) ? cyc : rise_cyc;
            rise_cyc = r;
            took = 1'b0;
            if (out_valid && out_ready) begin
                took = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=sum1 %0d required=no result", sum1);
                end else begin
                    e = sb.pop_front();
                    $display("result sum1=%0d sum2=%0d mcnt1=%0d mcnt2=%0d rise=%0d", sum1, sum2, mcnt1, mcnt2, r);
                    chk("sum1", sum1, e.s1);
                    chk("sum2", sum2, e.s2);
                    chk("mcnt1", mcnt1, e.m1);
                    chk("mcnt2", mcnt2, e.m2);
                    chk("latency", r, e.rise);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame back-to-back (optional one idle cycle) and pushes its expectation.
    task automatic send(input vec_t v);
        exp_t e;
        int   k;
        k = -1;
        for (int b = 0; b < N; b++) begin
            if (b > 0 && v.gap_after == b - 1) begin
                tick();
                in_valid = 1'b0;
            end
            tick();
            if (b == 0) begin
                k = cyc;
                e.s1 = v.s1;
                e.s2 = v.s2;
                e.m1 = v.m1;
                e.m2 = v.m2;
                e.rise = k + N + ((v.gap_after >= 0) ? 1 : 0);
                sb.push_back(e);
            end
            in_valid = 1'b1;
            in1 = v.in1[b];
            in2 = v.in2[b];
            ct1 = v.ct1[b];
            ct2 = v.ct2[b];
            @(negedge clk);
            chk("in_ready_beat", in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout actual=pending %0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        ct1 = 1'b0;
        ct2 = 1'b0;
        out_ready = 1'b1;

        vecs[0].in1 = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].in2 = {8'd40, 8'd30, 8'd20, 8'd10};
        vecs[0].ct1 = 4'b0000; vecs[0].ct2 = 4'b0000; vecs[0].gap_after = -1;
        vecs[0].s1 = 10; vecs[0].s2 = 100; vecs[0].m1 = 0; vecs[0].m2 = 0;

        vecs[1] = vecs[0];
        vecs[1].ct1 = 4'b1010; vecs[1].ct2 = 4'b0001;
        vecs[1].s1 = 4; vecs[1].s2 = 90; vecs[1].m1 = 2; vecs[1].m2 = 1;

        vecs[2].in1 = {8'd255, 8'd255, 8'd255, 8'd255};
        vecs[2].in2 = {8'd255, 8'd255, 8'd255, 8'd255};
        vecs[2].ct1 = 4'b0000; vecs[2].ct2 = 4'b0000; vecs[2].gap_after = 1;
        vecs[2].s1 = 1020; vecs[2].s2 = 1020; vecs[2].m1 = 0; vecs[2].m2 = 0;

        vecs[3].in1 = {8'd200, 8'd201, 8'd202, 8'd203};
        vecs[3].in2 = {8'd9, 8'd8, 8'd7, 8'd6};
        vecs[3].ct1 = 4'b1111; vecs[3].ct2 = 4'b0110; vecs[3].gap_after = -1;
        vecs[3].s1 = 0; vecs[3].s2 = 15; vecs[3].m1 = 4; vecs[3].m2 = 2;

        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum1", sum1, 0);
        chk("rst_sum2", sum2, 0);
        chk("rst_mcnt1", mcnt1, 0);
        chk("rst_mcnt2", mcnt2, 0);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i]);
            drain();
        end

        // Backpressure: HOLD ignores offered beats and keeps the result stable.
        out_ready = 1'b0;
        send(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum1", sum1, 10);
            chk("bp_sum2", sum2, 100);
            tick();
            in_valid = 1'b1;
            in1 = 8'd99;
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
        send(vecs[1]);
        drain();

        // Reset mid-frame: partial sums vanish without a result.
        v = vecs[0];
        tick();
        in_valid = 1'b1; in1 = 8'd7; in2 = 8'd7; ct1 = 1'b0; ct2 = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 0);
        end
        v.in1 = {8'd1, 8'd1, 8'd1, 8'd1};
        v.in2 = {8'd1, 8'd1, 8'd1, 8'd1};
        v.s1 = 4; v.s2 = 4;
        send(v);
        drain();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
